lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 35 +++
 rtl/lsu_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response and memory port bundle for the load/store unit.
// The slave modport is the lsu_ctrl side; the master modport is the pipeline/memory environment.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  memOffset;
  logic        unsignedFlag;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  MemRead, MemWrite, memOffset, unsignedFlag, addr, data_in,
    output mem_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output MemRead, MemWrite, memOffset, unsignedFlag, addr, data_in,
    input  mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: issues aligned accesses directly and splits misaligned
// ones into little-endian byte accesses, with fully registered outputs.
module lsu_ctrl #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] asm_q, asm_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [2:0]  mem_offset_q, mem_offset_d;
  logic        unsigned_flag_q, unsigned_flag_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] data_in_q, data_in_d;

  logic [31:0] asm_next;
  logic [1:0]  k_next;
  logic [1:0]  k_last;

  function automatic logic is_onehot(input logic [2:0] s);
    return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] s, input logic [1:0] a);
    return (s[2] && (a != 2'b00)) || (s[1] && a[0]);
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] s, input logic uns);
    logic [31:0] r;
    case (s)
      3'b001:  r = {{24{~uns & d[7]}}, d[7:0]};
      3'b010:  r = {{16{~uns & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d         = state_q;
    write_d         = write_q;
    size_d          = size_q;
    unsigned_d      = unsigned_q;
    base_d          = base_q;
    wdata_d         = wdata_q;
    k_d             = k_q;
    asm_d           = asm_q;
    req_ready_d     = 1'b0;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = 32'd0;
    resp_err_d      = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_offset_d    = 3'b000;
    unsigned_flag_d = 1'b0;
    mem_addr_d      = 32'd0;
    data_in_d       = 32'd0;
    asm_next        = asm_q;
    asm_next[{k_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
    k_next          = k_q + 2'd1;
    k_last          = size_q[2] ? 2'd3 : 2'd1;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          write_d    = bus.req_write;
          size_d     = bus.req_size;
          unsigned_d = bus.req_unsigned;
          base_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          k_d        = 2'd0;
          asm_d      = 32'd0;
          if (!is_onehot(bus.req_size) ||
              (is_misaligned(bus.req_size, bus.req_addr[1:0]) && (SPLIT_EN == 1'b0))) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
            state_d         = ACCESS;
            mem_read_d      = ~bus.req_write;
            mem_write_d     = bus.req_write;
            mem_offset_d    = bus.req_size;
            unsigned_flag_d = 1'b1;
            mem_addr_d      = bus.req_addr;
            data_in_d       = bus.req_wdata;
          end else begin
            state_d         = SPLIT;
            mem_read_d      = ~bus.req_write;
            mem_write_d     = bus.req_write;
            mem_offset_d    = 3'b001;
            unsigned_flag_d = 1'b1;
            mem_addr_d      = bus.req_addr;
            data_in_d       = {24'd0, bus.req_wdata[7:0]};
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = write_q ? 32'd0 : extend(bus.mem_rdata, size_q, unsigned_q);
      end
      SPLIT: begin
        asm_d = asm_next;
        // Byte k's read data arrives on the edge that closes its cycle.
        if (k_q == k_last) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? 32'd0 : extend(asm_next, size_q, unsigned_q);
        end else begin
          k_d             = k_next;
          mem_read_d      = ~write_q;
          mem_write_d     = write_q;
          mem_offset_d    = 3'b001;
          unsigned_flag_d = 1'b1;
          mem_addr_d      = base_q + {30'd0, k_next};
          data_in_d       = {24'd0, wdata_q[{k_next, 3'b000} +: 8]};
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State, captured request and all outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      write_q         <= 1'b0;
      size_q          <= 3'b000;
      unsigned_q      <= 1'b0;
      base_q          <= 32'd0;
      wdata_q         <= 32'd0;
      k_q             <= 2'd0;
      asm_q           <= 32'd0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 32'd0;
      resp_err_q      <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_offset_q    <= 3'b000;
      unsigned_flag_q <= 1'b0;
      mem_addr_q      <= 32'd0;
      data_in_q       <= 32'd0;
    end else begin
      state_q         <= state_d;
      write_q         <= write_d;
      size_q          <= size_d;
      unsigned_q      <= unsigned_d;
      base_q          <= base_d;
      wdata_q         <= wdata_d;
      k_q             <= k_d;
      asm_q           <= asm_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_offset_q    <= mem_offset_d;
      unsigned_flag_q <= unsigned_flag_d;
      mem_addr_q      <= mem_addr_d;
      data_in_q       <= data_in_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.MemRead      = mem_read_q;
  assign bus.MemWrite     = mem_write_q;
  assign bus.memOffset    = mem_offset_q;
  assign bus.unsignedFlag = unsigned_flag_q;
  assign bus.addr         = mem_addr_q;
  assign bus.data_in      = data_in_q;

endmodule
